// File: rtl/acc_mem_pkg.sv
// acc_mem_pkg: shared types and default sizes for the accelerator memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT_READ, RESP)
//   arb_op_t    : latched operation kind of the current grant
//   DEF_*       : default parameter values for the arbiter and its picker
//   idx_width   : bit width of a unit index (at least 1 bit)
package acc_mem_pkg;

  localparam int DEF_NUM_ACC          = 4;
  localparam int DEF_ADDR_SIZE        = 16;
  localparam int DEF_READ_DATA_SIZE   = 512;
  localparam int DEF_WRITE_DATA_SIZE  = 32;
  localparam int DEF_MEM_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_READ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_rr_picker.sv
// acc_rr_picker: combinational round-robin priority encoder.
//   req     in  NUM_ACC  request vector, one bit per unit
//   rr_ptr  in  IDX_W    index holding highest priority this round
//   gnt_idx out IDX_W    first requesting index at or after rr_ptr (mod NUM_ACC)
//   any_req out 1        at least one request bit is set
module acc_rr_picker
  import acc_mem_pkg::*;
#(
  parameter int NUM_ACC = DEF_NUM_ACC,
  localparam int IDX_W  = idx_width(NUM_ACC)
) (
  input  logic [NUM_ACC-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    // Walk outward from rr_ptr; the first hit wins and later hits are ignored.
    for (int k = 0; k < NUM_ACC; k++) begin
      int u;
      u = int'(rr_ptr) + k;
      if (u >= NUM_ACC) u = u - NUM_ACC;
      if (!any_req && req[u]) begin
        any_req = 1'b1;
        gnt_idx = IDX_W'(u);
      end
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: round-robin sharing of the accelerator Data Memory port.
//   clk, rst                     clock, synchronous active-high reset
//   acc_read_en / acc_read_addr  per-unit level read requests + packed addresses
//   acc_write_en / _addr / _data per-unit level write requests + packed addr/data
//   acc_read_data                registered read line, broadcast to all units
//   acc_read_data_valid          one-hot one-cycle read completion pulse
//   acc_write_done               one-hot one-cycle write completion pulse
//   mem_ready                    port free of the CPU (sampled only in IDLE)
//   mem_read_en / mem_write_en   one-cycle memory strobes
//   mem_addr / mem_write_data    memory address and write word
//   mem_read_data                memory read line, valid MEM_READ_LATENCY cycles
//                                after the mem_read_en cycle
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int NUM_ACC          = DEF_NUM_ACC,
  parameter int ADDR_SIZE        = DEF_ADDR_SIZE,
  parameter int READ_DATA_SIZE   = DEF_READ_DATA_SIZE,
  parameter int WRITE_DATA_SIZE  = DEF_WRITE_DATA_SIZE,
  parameter int MEM_READ_LATENCY = DEF_MEM_READ_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ACC-1:0]             acc_read_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]   acc_read_addr,
  input  logic [NUM_ACC-1:0]             acc_write_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]   acc_write_addr,
  input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data,
  output logic [READ_DATA_SIZE-1:0]      acc_read_data,
  output logic [NUM_ACC-1:0]             acc_read_data_valid,
  output logic [NUM_ACC-1:0]             acc_write_done,
  input  logic                           mem_ready,
  output logic                           mem_read_en,
  output logic                           mem_write_en,
  output logic [ADDR_SIZE-1:0]           mem_addr,
  output logic [WRITE_DATA_SIZE-1:0]     mem_write_data,
  input  logic [READ_DATA_SIZE-1:0]      mem_read_data
);

  localparam int IDX_W = idx_width(NUM_ACC);
  localparam int CNT_W = $clog2(MEM_READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT      = CNT_W'(MEM_READ_LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACC - 1);

  arb_state_t           state;
  arb_op_t              op;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt;
  logic [CNT_W-1:0]     lat_cnt;

  logic [NUM_ACC-1:0]   req;
  logic [IDX_W-1:0]     pick;
  logic                 any_req;
  logic [NUM_ACC-1:0]   gnt_onehot;

  assign req        = acc_read_en | acc_write_en;
  assign gnt_onehot = NUM_ACC'(1) << gnt;

  acc_rr_picker #(
    .NUM_ACC (NUM_ACC)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_idx (pick),
    .any_req (any_req)
  );

  // mem_addr / mem_write_data double as the latched request registers: they are
  // loaded at grant time so the strobe and address appear together in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      op                  <= OP_READ;
      rr_ptr              <= '0;
      gnt                 <= '0;
      lat_cnt             <= '0;
      mem_read_en         <= 1'b0;
      mem_write_en        <= 1'b0;
      mem_addr            <= '0;
      mem_write_data      <= '0;
      acc_read_data       <= '0;
      acc_read_data_valid <= '0;
      acc_write_done      <= '0;
    end else begin
      mem_read_en         <= 1'b0;
      mem_write_en        <= 1'b0;
      acc_read_data_valid <= '0;
      acc_write_done      <= '0;
      case (state)
        IDLE: begin
          if (mem_ready && any_req) begin
            gnt <= pick;
            // A unit raising both read and write gets its write served first.
            if (acc_write_en[pick]) begin
              op             <= OP_WRITE;
              mem_addr       <= acc_write_addr[int'(pick)*ADDR_SIZE +: ADDR_SIZE];
              mem_write_data <= acc_write_data[int'(pick)*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
              mem_write_en   <= 1'b1;
            end else begin
              op             <= OP_READ;
              mem_addr       <= acc_read_addr[int'(pick)*ADDR_SIZE +: ADDR_SIZE];
              mem_read_en    <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (op == OP_WRITE) begin
            acc_write_done <= gnt_onehot;
            state          <= RESP;
          end else begin
            lat_cnt <= CNT_W'(1);
            state   <= WAIT_READ;
          end
        end
        WAIT_READ: begin
          // lat_cnt equals the number of cycles since the mem_read_en cycle.
          if (lat_cnt == LAT) begin
            acc_read_data       <= mem_read_data;
            acc_read_data_valid <= gnt_onehot;
            state               <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          // Done pulse is on the outputs this cycle; the served unit moves to
          // lowest priority, and IDLE next cycle sees its dropped request.
          rr_ptr <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_mem_arbiter.md
# acc_mem_arbiter

Shares the single accelerator-side Data Memory port among `NUM_ACC` accelerator control units. Each requester holds a level read or write request. The arbiter grants requests round-robin, runs the memory access, and returns a one-cycle `read_data_valid` or `write_done` pulse to the granted unit. It sits directly downstream of every accelerator control unit and upstream of the Data Memory accelerator port. CPU ownership of the port is signalled through `mem_ready`.

## Interface
- `NUM_ACC`, 4: number of accelerator control units served.
- `ADDR_SIZE`, 16: memory address width, shared by read and write.
- `READ_DATA_SIZE`, 512: width of a read line.
- `WRITE_DATA_SIZE`, 32: width of a write word.
- `MEM_READ_LATENCY`, 1: cycles from the `mem_read_en` cycle until `mem_read_data` is valid; must be ≥1.

- `clk`  in  1  clock. This is the only clock; the block uses one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `acc_read_en`  in  NUM_ACC  per-unit read request, held until `acc_read_data_valid`.
- `acc_read_addr`  in  NUM_ACC*ADDR_SIZE  packed read addresses; unit i occupies slice i.
- `acc_write_en`  in  NUM_ACC  per-unit write request, held until `acc_write_done`.
- `acc_write_addr`  in  NUM_ACC*ADDR_SIZE  packed write addresses.
- `acc_write_data`  in  NUM_ACC*WRITE_DATA_SIZE  packed write words.
- `acc_read_data`  out  READ_DATA_SIZE  registered read line, broadcast to all units.
- `acc_read_data_valid`  out  NUM_ACC  one-hot one-cycle pulse marking read completion.
- `acc_write_done`  out  NUM_ACC  one-hot one-cycle pulse marking write completion.
- `mem_ready`  in  1  high when the memory port is free (CPU not using it).
- `mem_read_en`, `mem_write_en`  out  1  memory strobes, one cycle each.
- `mem_addr`  out  ADDR_SIZE  memory address.
- `mem_write_data`  out  WRITE_DATA_SIZE  memory write word.
- `mem_read_data`  in  READ_DATA_SIZE  memory read line.

## Operation
- **Reset values:** all outputs are 0, `state`=IDLE, `rr_ptr`=0, the latency counter is 0.
- **Request definition:** unit i requests when `acc_read_en[i]|acc_write_en[i]`. If a unit raises both, the write is served first; its read is then served on a later grant.
- **IDLE:**
  - Stays in IDLE if `mem_ready`=0 or there is no request.
  - Otherwise grants the first requesting index at or after `rr_ptr`, wrapping modulo `NUM_ACC`.
  - Latches grant index, op, address and data into registers, then goes to ISSUE.
- **ISSUE:** drives `mem_addr` (and `mem_write_data` for writes) from the latched registers and pulses the matching strobe.
  - Write: go to RESP.
  - Read: go to WAIT_READ with the counter set to 1.
- **WAIT_READ:** increments the counter each cycle.
  - When counter == `MEM_READ_LATENCY`, capture `mem_read_data` into `acc_read_data` and go to RESP.
- **RESP:** pulses `acc_write_done[g]` or `acc_read_data_valid[g]`, sets `rr_ptr` = (g+1) mod `NUM_ACC`, and returns to IDLE.
- **Data hold:** `acc_read_data` holds its value until the next read capture.
- **Re-arbitration:** IDLE only re-arbitrates on the cycle after RESP. By then the served unit has left its request state, so a stale re-grant cannot occur. A new request from the same unit is treated as fresh.
- **`mem_ready` scope:** sampled only in IDLE. An issued access always completes.
- **Request drop mid-access:** if a requester drops its request during an access, the access still completes and the done pulse is still emitted.
- **Reset mid-operation:** the access is abandoned with no done pulse. Held requests are re-arbitrated after reset.
- **Addresses:** passed through unmodified. Address arithmetic and word/byte units are the requester's concern.

## Timing
- **Write:** request seen in IDLE at cycle t → `mem_write_en` at t+1 → `acc_write_done` at t+2.
- **Read:** request seen at t → `mem_read_en` at t+1 → capture at t+1+L → `acc_read_data_valid` at t+2+L, where L = `MEM_READ_LATENCY`.
- **Throughput:** back-to-back grants start every 3 cycles for writes and 3+L cycles for reads.
- **Fairness:** with all units requesting continuously, each unit waits at most `NUM_ACC`-1 other accesses.
- **Strobes:** `mem_*_en` and the done pulses are exactly one cycle wide and registered.

## Structure
- Shared package `acc_mem_pkg` holds:
  - `arb_state_t` enum: IDLE, ISSUE, WAIT_READ, RESP.
  - `arb_op_t` enum: OP_READ, OP_WRITE.
  - Default width constants.
- Sub-module `acc_rr_picker` is a combinational round-robin priority encoder.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: grant index, `any_req`.

## Test plan
- **Single write:** `NUM_ACC`=4; unit 2 writes 0x00000005 to 0x5000 → `mem_write_en`=1, `mem_addr`=0x5000 at t+1; `acc_write_done`=4'b0100 at t+2; no other pulses.
- **Single read:** L=2; unit 0 reads 0x1010; memory returns 512'hA5…A5 two cycles later → `acc_read_data_valid`=4'b0001 at t+4 with `acc_read_data`=512'hA5…A5.
- **Round-robin:** all four units hold write requests from reset → grants in order 0,1,2,3,0; no unit is granted twice before all others are served.
- **CPU ownership:** `mem_ready`=0 for 10 cycles with unit 1 requesting → no strobes. `mem_ready`=1 at cycle 10 → `mem_write_en` at cycle 11.
- **Reset mid-read:** `rst` asserted during WAIT_READ → next cycle all outputs 0 and `state`=IDLE, with no `valid` pulse. After reset, the held request is reissued and completes normally.
- **Write-before-read:** unit 3 asserts read and write together → write completes first, then the read on a later grant.
